alu_issue: RTL

//  Instruction-side partner of the 16-bit LC-3b ALU: accepts operate instructions over a valid/ready handshake.

---
 rtl/alu_issue.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/alu_issue.sv
`default_nettype none
// ----------------------------------------------------------------------------
// alu_issue : LC-3b operate-instruction issue/writeback stage for an external
//             combinational ALU (8x16 regfile, NZP codes, 2-cycle latency)
// Rev 1.0
// ----------------------------------------------------------------------------
module alu_issue #(
   parameter int         DATA_W   = 16,
   parameter logic [2:0] RESET_CC = 3'b010
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              instValid,
   input  logic [15:0]       instData,
   output logic              instReady,
   output logic [2:0]        aluControl,
   output logic [DATA_W-1:0] aluA,
   output logic [DATA_W-1:0] aluB,
   input  logic [DATA_W-1:0] aluResult,
   output logic [2:0]        cc,
   output logic              done,
   output logic              illegal,
   input  logic [2:0]        dbgAddr,
   output logic [DATA_W-1:0] dbgData
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      EXEC   = 2'd1,
      RETIRE = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [DATA_W-1:0] regs_q [8];
   logic [DATA_W-1:0] regs_d [8];
   logic [2:0]        ctrl_q, ctrl_d;
   logic [DATA_W-1:0] a_q, a_d;
   logic [DATA_W-1:0] b_q, b_d;
   logic [2:0]        dr_q, dr_d;
   logic [2:0]        cc_q, cc_d;
   logic              ill_q, ill_d;

   logic [3:0]        opcode;
   logic [DATA_W-1:0] imm_sext;
   logic [DATA_W-1:0] amt_zext;
   logic [DATA_W-1:0] sr1_val;
   logic [DATA_W-1:0] arith_b;
   logic              res_n;
   logic              res_z;
   logic [2:0]        res_nzp;

   assign opcode   = instData[15:12];
   assign imm_sext = {{(DATA_W-5){instData[4]}}, instData[4:0]};
   assign amt_zext = {{(DATA_W-4){1'b0}}, instData[3:0]};
   assign sr1_val  = regs_q[instData[8:6]];
   // bit 5 selects immediate vs. SR2 for ADD/AND/XOR
   assign arith_b  = instData[5] ? imm_sext : regs_q[instData[2:0]];

   assign res_n   = aluResult[DATA_W-1];
   assign res_z   = (aluResult == '0);
   assign res_nzp = {res_n, res_z, ~res_n & ~res_z};

   always_comb begin
      state_d   = state_q;
      regs_d    = regs_q;
      ctrl_d    = ctrl_q;
      a_d       = a_q;
      b_d       = b_q;
      dr_d      = dr_q;
      cc_d      = cc_q;
      ill_d     = ill_q;
      instReady = 1'b0;
      case (state_q)
         IDLE: begin
            instReady = 1'b1;
            if (instValid) begin
               dr_d    = instData[11:9];
               ill_d   = 1'b0;
               state_d = EXEC;
               case (opcode)
                  4'b0001: begin ctrl_d = 3'd0; a_d = sr1_val; b_d = arith_b; end
                  4'b0101: begin ctrl_d = 3'd1; a_d = sr1_val; b_d = arith_b; end
                  4'b1001: begin ctrl_d = 3'd2; a_d = sr1_val; b_d = arith_b; end
                  4'b1101: begin
                     a_d = sr1_val;
                     b_d = amt_zext;
                     // bit 4 = right shift, bit 5 = arithmetic (only meaningful for right)
                     if (!instData[4])     ctrl_d = 3'd3;
                     else if (instData[5]) ctrl_d = 3'd5;
                     else                  ctrl_d = 3'd4;
                  end
                  default: begin
                     ctrl_d  = 3'd6;
                     ill_d   = 1'b1;
                     state_d = RETIRE;
                  end
               endcase
            end
         end
         EXEC: begin
            regs_d[dr_q] = aluResult;
            cc_d         = res_nzp;
            state_d      = RETIRE;
         end
         RETIRE:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         for (int i = 0; i < 8; i++) regs_q[i] <= '0;
         ctrl_q  <= 3'd0;
         a_q     <= '0;
         b_q     <= '0;
         dr_q    <= 3'd0;
         cc_q    <= RESET_CC;
         ill_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         for (int i = 0; i < 8; i++) regs_q[i] <= regs_d[i];
         ctrl_q  <= ctrl_d;
         a_q     <= a_d;
         b_q     <= b_d;
         dr_q    <= dr_d;
         cc_q    <= cc_d;
         ill_q   <= ill_d;
      end
   end

   assign aluControl = ctrl_q;
   assign aluA       = a_q;
   assign aluB       = b_q;
   assign cc         = cc_q;
   assign done       = (state_q == RETIRE) & ~ill_q;
   assign illegal    = (state_q == RETIRE) &  ill_q;
   assign dbgData    = regs_q[dbgAddr];

endmodule
`default_nettype wire
